// File: rtl/button_bank.sv
// button_bank: N-channel push-button front end (sync, debounce, press/release edges, hold auto-repeat, long press).
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined; otherwise btn_long is tied low.
module button_bank #(
    parameter int N_BTN             = 5,
    parameter int DEBOUNCE_CYC      = 1_000_000,
    parameter int REPEAT_DELAY_CYC  = 50_000_000,
    parameter int REPEAT_PERIOD_CYC = 10_000_000,
    parameter int LONG_CYC          = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_long
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_MAX = (LONG_CYC > REPEAT_DELAY_CYC) ? LONG_CYC : REPEAT_DELAY_CYC;
`else
    localparam int HOLD_MAX = REPEAT_DELAY_CYC;
`endif
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam int REP_W  = $clog2(REPEAT_PERIOD_CYC);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] DLY_LAST  = HOLD_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_PERIOD_CYC - 1);
`ifdef BTN_LONG_PRESS_EN
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
`endif

    if (DEBOUNCE_CYC < 2 || REPEAT_DELAY_CYC < 2 || REPEAT_PERIOD_CYC < 2 || LONG_CYC < 2) begin : g_bad_min
        $error("button_bank: all cycle parameters must be at least 2");
    end
    if (REPEAT_PERIOD_CYC > REPEAT_DELAY_CYC) begin : g_bad_period
        $error("button_bank: REPEAT_PERIOD_CYC must not exceed REPEAT_DELAY_CYC");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } hold_state_t;

`ifndef BTN_LONG_PRESS_EN
    assign btn_long = '0;
`endif

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic              r_sync1;
        logic              r_sync2;
        logic              r_stable;
        logic [DB_W-1:0]   r_db_cnt;
        hold_state_t       r_state;
        logic [HOLD_W-1:0] r_hold;
        logic [REP_W-1:0]  r_rep;
        logic              r_press;
        logic              r_release;
        logic              r_repeat;
        logic              w_flip;
        logic              w_rise;
        logic              w_fall;

        // Stable level flips on the edge where the counter would reach DEBOUNCE_CYC.
        assign w_flip = (r_sync2 != r_stable) && (r_db_cnt == DB_LAST);
        assign w_rise = w_flip & ~r_stable;
        assign w_fall = w_flip & r_stable;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_stable <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_sync1 <= btn_raw[g];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_stable) begin
                    r_db_cnt <= '0;
                end else if (w_flip) begin
                    r_stable <= ~r_stable;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

`ifdef BTN_LONG_PRESS_EN
        logic r_long;
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state   <= S_IDLE;
                r_hold    <= '0;
                r_rep     <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
                r_long    <= 1'b0;
`endif
            end else begin
                r_press   <= w_rise;
                r_release <= w_fall;
                r_repeat  <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
                r_long    <= 1'b0;
`endif
                if (w_fall) begin
                    r_state <= S_IDLE;
                    r_hold  <= '0;
                    r_rep   <= '0;
                end else begin
                    if (r_state != S_IDLE) begin
                        if (r_hold != HOLD_TOP) begin
                            r_hold <= r_hold + 1'b1;
                        end
`ifdef BTN_LONG_PRESS_EN
                        if (r_hold == LONG_LAST) begin
                            r_long <= 1'b1;
                        end
`endif
                    end
                    case (r_state)
                        S_IDLE: begin
                            if (w_rise) begin
                                r_state <= S_DELAY;
                                r_hold  <= '0;
                                r_rep   <= '0;
                            end
                        end
                        S_DELAY: begin
                            // >= rather than == so a late re-enable fires on the very next cycle.
                            if (repeat_en[g] && (r_hold >= DLY_LAST)) begin
                                r_repeat <= 1'b1;
                                r_rep    <= '0;
                                r_state  <= S_REPEAT;
                            end
                        end
                        S_REPEAT: begin
                            if (!repeat_en[g]) begin
                                r_state <= S_DELAY;
                            end else if (r_rep == REP_LAST) begin
                                r_repeat <= 1'b1;
                                r_rep    <= '0;
                            end else begin
                                r_rep <= r_rep + 1'b1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end

        assign btn_level[g]   = r_stable;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
        assign btn_repeat[g]  = r_repeat;
`ifdef BTN_LONG_PRESS_EN
        assign btn_long[g]    = r_long;
`endif
    end

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: directed stimulus for button_bank with a cycle-level behavioural model and literal timing checks.
// Expectations for btn_long follow BTN_LONG_PRESS_EN.
module tb_button_bank;
    localparam int NB = 3;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int LG = 40;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] repeat_en;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;
    logic [NB-1:0] btn_long;

    button_bank #(
        .N_BTN(NB),
        .DEBOUNCE_CYC(DB),
        .REPEAT_DELAY_CYC(RD),
        .REPEAT_PERIOD_CYC(RP),
        .LONG_CYC(LG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .repeat_en(repeat_en),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_repeat(btn_repeat),
        .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: raw samples per channel (index 0 = most recent edge), stable level, and hold age since press.
    bit            samp [NB][DB+1];
    bit            m_stab [NB];
    bit            m_held [NB];
    int            m_age [NB];
    int            m_last [NB];
    logic [NB-1:0] e_level, e_press, e_release, e_repeat, e_long;

    typedef struct {
        int kind;
        int ch;
        int t;
    } ev_t;
    ev_t evq[$];

    localparam int EV_PRESS = 0, EV_REL = 1, EV_REP = 2, EV_LONG = 3;

    task automatic model_clear();
        for (int c = 0; c < NB; c++) begin
            for (int j = 0; j <= DB; j++) samp[c][j] = 1'b0;
            m_stab[c] = 1'b0;
            m_held[c] = 1'b0;
            m_age[c]  = 0;
            m_last[c] = -1;
        end
        e_level = '0; e_press = '0; e_release = '0; e_repeat = '0; e_long = '0;
    endtask

    task automatic model_step();
        bit flip;
        if (reset) begin
            model_clear();
            return;
        end
        for (int c = 0; c < NB; c++) begin
            e_press[c] = 1'b0; e_release[c] = 1'b0; e_repeat[c] = 1'b0; e_long[c] = 1'b0;
            // Flip once the synchronised input (raw two edges back) has disagreed for DB edges in a row.
            flip = 1'b1;
            for (int j = 1; j <= DB; j++) if (samp[c][j] == m_stab[c]) flip = 1'b0;
            for (int j = DB; j >= 1; j--) samp[c][j] = samp[c][j-1];
            samp[c][0] = btn_raw[c];
            if (flip) begin
                m_stab[c] = ~m_stab[c];
                if (m_stab[c]) begin
                    e_press[c] = 1'b1;
                    m_held[c]  = 1'b1;
                    m_age[c]   = 0;
                    m_last[c]  = -1;
                end else begin
                    e_release[c] = 1'b1;
                    m_held[c]    = 1'b0;
                end
            end else if (m_held[c]) begin
                m_age[c]++;
                if (!repeat_en[c]) begin
                    m_last[c] = -1;
                end else if ((m_last[c] < 0) ? (m_age[c] >= RD) : (m_age[c] - m_last[c] == RP)) begin
                    e_repeat[c] = 1'b1;
                    m_last[c]   = m_age[c];
                end
                if (LONG_ON && m_age[c] == LG) e_long[c] = 1'b1;
            end
            e_level[c] = m_stab[c];
        end
    endtask

    task automatic check_v(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int count_ev(input int kind, input int ch, input int lo, input int hi);
        int n = 0;
        foreach (evq[i]) if (evq[i].kind == kind && evq[i].ch == ch && evq[i].t >= lo && evq[i].t <= hi) n++;
        return n;
    endfunction

    function automatic int first_ev(input int kind, input int ch, input int lo, input int hi);
        foreach (evq[i]) if (evq[i].kind == kind && evq[i].ch == ch && evq[i].t >= lo && evq[i].t <= hi) return evq[i].t;
        return -1;
    endfunction

    function automatic int last_ev(input int kind, input int ch, input int lo, input int hi);
        int r = -1;
        foreach (evq[i]) if (evq[i].kind == kind && evq[i].ch == ch && evq[i].t >= lo && evq[i].t <= hi) r = evq[i].t;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check_v("level", btn_level, e_level);
        check_v("press", btn_press, e_press);
        check_v("release", btn_release, e_release);
        check_v("repeat", btn_repeat, e_repeat);
        check_v("long", btn_long, e_long);
        for (int c = 0; c < NB; c++) begin
            if (btn_press[c] === 1'b1)   evq.push_back('{kind: EV_PRESS, ch: c, t: cyc});
            if (btn_release[c] === 1'b1) evq.push_back('{kind: EV_REL, ch: c, t: cyc});
            if (btn_repeat[c] === 1'b1)  evq.push_back('{kind: EV_REP, ch: c, t: cyc});
            if (btn_long[c] === 1'b1)    evq.push_back('{kind: EV_LONG, ch: c, t: cyc});
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        reset     = 1'b1;
        btn_raw   = '0;
        repeat_en = '0;
        model_clear();
        #1;
        check_v("rst_level", btn_level, 3'b000);
        check_v("rst_press", btn_press, 3'b000);
        check_v("rst_release", btn_release, 3'b000);
        check_v("rst_repeat", btn_repeat, 3'b000);
        check_v("rst_long", btn_long, 3'b000);
        run_to(2);
        reset     = 1'b0;
        repeat_en = 3'b001;

        // ch0 clean press sampled from edge 10, held through edge 69, repeats enabled.
        run_to(9);
        btn_raw[0] = 1'b1;
        run_to(14);
        check_i("ch0_level_before", int'(btn_level[0]), 0);
        run_to(15);
        check_i("ch0_level_at15", int'(btn_level[0]), 1);
        check_i("ch0_press_at15", int'(btn_press[0]), 1);
        run_to(16);
        check_i("ch0_press_width", int'(btn_press[0]), 0);
        run_to(69);
        btn_raw[0] = 1'b0;
        run_to(90);
        check_i("ch0_press_time", first_ev(EV_PRESS, 0, 0, 90), 15);
        check_i("ch0_press_count", count_ev(EV_PRESS, 0, 0, 90), 1);
        check_i("ch0_rep_count", count_ev(EV_REP, 0, 0, 90), 8);
        check_i("ch0_rep_first", first_ev(EV_REP, 0, 0, 90), 35);
        check_i("ch0_rep_last", last_ev(EV_REP, 0, 0, 90), 70);
        check_i("ch0_release", first_ev(EV_REL, 0, 0, 90), 75);
        check_i("ch0_long_count", count_ev(EV_LONG, 0, 0, 90), LONG_ON ? 1 : 0);
        if (LONG_ON) check_i("ch0_long_time", first_ev(EV_LONG, 0, 0, 90), 55);

        // ch1 bounce 1,0,1,0 then steady 1 from edge 104; repeat enabled late, then dropped.
        run_to(99);  btn_raw[1] = 1'b1;
        run_to(100); btn_raw[1] = 1'b0;
        run_to(101); btn_raw[1] = 1'b1;
        run_to(102); btn_raw[1] = 1'b0;
        run_to(103); btn_raw[1] = 1'b1;
        run_to(138); repeat_en[1] = 1'b1;
        run_to(145); repeat_en[1] = 1'b0;
        run_to(149); btn_raw[1] = 1'b0;
        run_to(170);
        check_i("ch1_no_press_bounce", count_ev(EV_PRESS, 1, 100, 108), 0);
        check_i("ch1_press_time", first_ev(EV_PRESS, 1, 100, 170), 109);
        check_i("ch1_rep_count", count_ev(EV_REP, 1, 100, 170), 2);
        check_i("ch1_rep_reenable", first_ev(EV_REP, 1, 100, 170), 139);
        check_i("ch1_rep_second", last_ev(EV_REP, 1, 100, 170), 144);
        check_i("ch1_release", first_ev(EV_REL, 1, 100, 170), 155);
        check_i("ch1_long_count", count_ev(EV_LONG, 1, 100, 170), LONG_ON ? 1 : 0);

        // ch0 60-cycle hold with repeat disabled.
        run_to(190); repeat_en[0] = 1'b0;
        run_to(199); btn_raw[0] = 1'b1;
        run_to(259); btn_raw[0] = 1'b0;
        run_to(280);
        check_i("ch0b_press", first_ev(EV_PRESS, 0, 200, 280), 205);
        check_i("ch0b_rep_none", count_ev(EV_REP, 0, 200, 280), 0);
        check_i("ch0b_release", first_ev(EV_REL, 0, 200, 280), 265);
        check_i("ch0b_long_count", count_ev(EV_LONG, 0, 200, 280), LONG_ON ? 1 : 0);
        if (LONG_ON) check_i("ch0b_long_time", first_ev(EV_LONG, 0, 200, 280), 245);

        // ch2 press, asynchronous reset mid-cycle at press+10, button still held afterwards.
        run_to(299); btn_raw[2] = 1'b1;
        run_to(315);
        check_i("ch2_level_held", int'(btn_level[2]), 1);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_v("async_level", btn_level, 3'b000);
        check_v("async_press", btn_press, 3'b000);
        check_v("async_release", btn_release, 3'b000);
        check_v("async_repeat", btn_repeat, 3'b000);
        check_v("async_long", btn_long, 3'b000);
        run_to(317);
        reset = 1'b0;
        run_to(340);
        btn_raw[2] = 1'b0;
        run_to(360);
        check_i("ch2_first_press", first_ev(EV_PRESS, 2, 300, 315), 305);
        check_i("ch2_no_release_reset", count_ev(EV_REL, 2, 300, 340), 0);
        check_i("ch2_repress", first_ev(EV_PRESS, 2, 316, 360), 323);
        check_i("ch2_release_after", first_ev(EV_REL, 2, 341, 360), 346);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
